// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity constants and sampling helper for uart_rx_cfg
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Mid-bit count; the three votes land at HALF-1, HALF and HALF+1.
  function automatic int uart_half(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchronizer, per-bit counter and 3-sample majority vote
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic restart_i,
  output logic rx_s_o,
  output logic bit_val_o,
  output logic bit_vld_o,
  output logic bit_end_o
);

  localparam int HALF = uart_half(CLKS_PER_BIT);
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_VOTE = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          s0_q;
  logic          s1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      if (restart_i || cnt_q == CNT_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cnt_q == CNT_S0) s0_q <= sync_q[1];
      if (cnt_q == CNT_S1) s1_q <= sync_q[1];
    end
  end

  // The third sample is the live synchronized line at the vote count.
  assign rx_s_o    = sync_q[1];
  assign bit_vld_o = (cnt_q == CNT_VOTE);
  assign bit_val_o = (s0_q & s1_q) | (s0_q & rx_s_o) | (s1_q & rx_s_o);
  assign bit_end_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with error flags and one-entry holding register
// Parity bit and parity checking are built only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 in_Clock,
  input  logic                 in_Reset,
  input  logic                 in_Rx_Serial,
  input  logic                 in_Rx_Ready,
  output logic                 out_Rx_Valid,
  output logic [DATA_BITS-1:0] out_Rx_Byte,
  output logic                 out_Frame_Err,
  output logic                 out_Parity_Err,
  output logic                 out_Break,
  output logic                 out_Overrun
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  logic rx_s, bit_val, bit_vld, bit_end, restart;

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           data_cnt_q;
  logic [1:0]           stop_cnt_q;
  logic                 fe_q, pe_q, par_bit_q;
  logic                 valid_q, ferr_q, perr_q, brk_q, ovr_q;
  logic [DATA_BITS-1:0] byte_q;
  logic                 fe_d, brk_d, take;

  assign restart = (state_q == WAIT_HIGH) || (state_q == IDLE);

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk_i    (in_Clock),
    .rst_i    (in_Reset),
    .rx_i     (in_Rx_Serial),
    .restart_i(restart),
    .rx_s_o   (rx_s),
    .bit_val_o(bit_val),
    .bit_vld_o(bit_vld),
    .bit_end_o(bit_end)
  );

  always_comb begin
    fe_d  = fe_q | (state_q == STOP && bit_vld && !bit_val);
    brk_d = fe_d && (shift_q == '0) && !par_bit_q;
    take  = valid_q && in_Rx_Ready;
  end

  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      state_q    <= WAIT_HIGH;
      shift_q    <= '0;
      data_cnt_q <= '0;
      stop_cnt_q <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      par_bit_q  <= 1'b0;
      valid_q    <= 1'b0;
      byte_q     <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (take) valid_q <= 1'b0;
      case (state_q)
        WAIT_HIGH: if (rx_s) state_q <= IDLE;
        IDLE: if (!rx_s) begin
          state_q    <= START;
          data_cnt_q <= '0;
          stop_cnt_q <= '0;
          fe_q       <= 1'b0;
          pe_q       <= 1'b0;
          par_bit_q  <= 1'b0;
        end
        START: begin
          if (bit_vld && bit_val) state_q <= IDLE;
          else if (bit_end) state_q <= DATA;
        end
        DATA: if (bit_vld) begin
          shift_q    <= {bit_val, shift_q[DATA_BITS-1:1]};
          data_cnt_q <= data_cnt_q + 4'd1;
          if (data_cnt_q == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_vld) begin
          par_bit_q <= bit_val;
          pe_q      <= (((^shift_q) ^ bit_val) != PARITY_ODD);
          state_q   <= STOP;
        end
`endif
        STOP: if (bit_vld) begin
          fe_q       <= fe_d;
          stop_cnt_q <= stop_cnt_q + 2'd1;
          if (stop_cnt_q == LAST_STOP) begin
            // Commit at the last stop vote; a full holder not being drained drops the word.
            if (!valid_q || take) begin
              valid_q <= 1'b1;
              byte_q  <= shift_q;
              ferr_q  <= fe_d;
              perr_q  <= pe_q;
              brk_q   <= brk_d;
            end else begin
              ovr_q <= 1'b1;
            end
            state_q <= brk_d ? WAIT_HIGH : IDLE;
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign out_Rx_Valid   = valid_q;
  assign out_Rx_Byte    = byte_q;
  assign out_Frame_Err  = ferr_q;
  assign out_Parity_Err = perr_q;
  assign out_Break      = brk_q;
  assign out_Overrun    = ovr_q;

endmodule
